fft_stream_sink: RTL
====================

# fft_stream_sink

Parametrised AXI-Stream sink for the FFT output port (M_AXIS_DATA) that replaces fixed, testbench-driven tready with programmable backpressure, checks frame framing against tlast, and reports the per-frame peak bin. It sits downstream of the FFT core in the range-processing chain. It serves both as a synthesizable on-chip monitor and as a self-checking endpoint for FFT regression runs.

## Interface
- DATA_W, 32: tdata width; {im[DATA_W/2-1:0], re[DATA_W/2-1:0]}, both signed two's complement; must be even.
- FRAME_LEN, 256: expected beats per frame; power of two, 8..65536.
- LFSR_SEED, 16'hACE1: reload value of the backpressure LFSR; must be nonzero.
- m_axis_aclk  in  1  sole clock; all logic on the rising edge.
- m_axis_areset  in  1  synchronous, active-high reset.
- enable  in  1  1 = accept stream; 0 = tready forced low after the current beat.
- bp_mode  in  2  backpressure mode: 0 always, 1 never, 2 periodic, 3 pseudo-random.
- bp_period  in  8  mode 2 period minus one.
- s_axis_tdata  in  DATA_W  FFT sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tlast  in  1  last sample of frame.
- s_axis_tready  out  1  registered ready.
- frame_done  out  1  one-cycle pulse when a frame closes.
- peak_bin  out  log2(FRAME_LEN)  index of max-magnitude sample in the closed frame.
- peak_mag  out  DATA_W/2+1  |re|+|im| of that sample, unsigned.
- frame_count  out  16  frames closed since reset; wraps at 65535->0.
- err_early_last  out  1  sticky: tlast seen before index FRAME_LEN-1.
- err_missing_last  out  1  sticky: no tlast at index FRAME_LEN-1.
- err_count  out  8  framing errors since reset; saturates at 255.

## Operation
- A beat is a cycle with s_axis_tvalid && s_axis_tready.
- States: IDLE (enable=0; tready=0; sample index held) and RECV (enable=1). IDLE->RECV when enable=1; RECV->IDLE when enable=0, taking effect on the next tready register update. A partial frame is kept and resumes on re-enable.
- Backpressure (tready_next is computed in RECV only):
  - Mode 0: tready_next=1.
  - Mode 1: tready_next=0.
  - Mode 2: cnt counts 0..bp_period and wraps; tready_next=(cnt==0). bp_period=0 gives always ready.
  - Mode 3: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts every cycle; tready_next=lfsr[0].
- tready never depends combinationally on tvalid, tlast or tdata.
- Magnitude per beat: mag=|re|+|im|. abs(-2^(N-1))=2^(N-1), no wrap.
- Peak tracking: the first beat of a frame loads the running max. Later beats replace it only when strictly greater, so ties keep the lowest index.
- Sample index idx: increments per beat; reset to 0 on frame close.
- Frame close on a beat when tlast=1 or idx==FRAME_LEN-1:
  - tlast=1 and idx==FRAME_LEN-1: clean close.
  - tlast=1 and idx<FRAME_LEN-1: set err_early_last, err_count+1.
  - idx==FRAME_LEN-1 and tlast=0: set err_missing_last, err_count+1. The following beats start a new frame.
- On every close, including erroneous ones: latch peak_bin/peak_mag, increment frame_count, pulse frame_done.

## Timing
- Reset (cycle with m_axis_areset=1): state=IDLE, tready=0, frame_done=0, peak_bin=0, peak_mag=0, frame_count=0, both error flags=0, err_count=0, idx=0, cnt=0, lfsr=LFSR_SEED.
- First possible tready=1 is the second clock edge after reset is released with enable=1 (one cycle to enter RECV, one cycle for the registered update).
- Mode 3: after reset, the tready sequence is deterministic from LFSR_SEED.
- Reset mid-frame: the partial frame is discarded, no frame_done is produced, and counters are cleared.
- frame_done, peak_bin, peak_mag and frame_count update together, exactly 1 cycle after the closing beat. Results hold until the next close.
- Closing beat in the same cycle as enable falling: the frame closes normally.
- Back-to-back frames are supported in mode 0 at 1 beat/cycle with no bubble.

## Test plan
- Mode 0, FRAME_LEN=8, 8 beats with |re|+|im| = 1,5,3,9,9,2,0,4 and tlast on beat 7 -> frame_done 1 cycle later; peak_bin=3, peak_mag=9, frame_count=1, no errors.
- tlast on beat 4 of an 8-sample frame -> err_early_last=1, err_count=1, frame_count=1. The next 8 clean beats close with frame_count=2, and err_early_last stays 1.
- 10 beats with no tlast -> err_missing_last=1 at beat 7 close. Beats 8-9 count as idx 0-1 of the next frame.
- Mode 2, bp_period=3, tvalid held high -> tready high 1 cycle in 4. An 8-beat frame closes after 29-32 cycles.
- Beat with re=-2^15, im=-2^15 (DATA_W=32) -> peak_mag=65536.
- Mode 3: two runs from reset produce identical tready sequences. Reset asserted mid-frame -> no frame_done, all outputs return to 0.

Source files
------------

// File: rtl/fft_stream_sink.sv
// AXI-Stream sink for FFT output: programmable backpressure,
// tlast framing checks and per-frame peak-bin reporting.
module fft_stream_sink #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAME_LEN = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int unsigned IDX_W    = $clog2(FRAME_LEN),
    localparam int unsigned HALF_W   = DATA_W / 2,
    localparam int unsigned MAG_W    = HALF_W + 1
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_areset,
    input  logic              enable,
    input  logic [1:0]        bp_mode,
    input  logic [7:0]        bp_period,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              frame_done,
    output logic [IDX_W-1:0]  peak_bin,
    output logic [MAG_W-1:0]  peak_mag,
    output logic [15:0]       frame_count,
    output logic              err_early_last,
    output logic              err_missing_last,
    output logic [7:0]        err_count
);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t            state_q, state_d;
    logic              tready_q, tready_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic [IDX_W-1:0]  idx_q;
    logic [MAG_W-1:0]  run_max_q;
    logic [IDX_W-1:0]  run_bin_q;
    logic              frame_done_q;
    logic [IDX_W-1:0]  peak_bin_q;
    logic [MAG_W-1:0]  peak_mag_q;
    logic [15:0]       frame_count_q;
    logic              err_early_q;
    logic              err_missing_q;
    logic [7:0]        err_count_q;

    logic              beat;
    logic              close;
    logic              at_last;
    logic [HALF_W-1:0] abs_re;
    logic [HALF_W-1:0] abs_im;
    logic [MAG_W-1:0]  mag;
    logic              take_new;
    logic [MAG_W-1:0]  cur_max;
    logic [IDX_W-1:0]  cur_bin;

    // Two's complement magnitude; the most negative value maps to
    // 2^(HALF_W-1) when the result is read as unsigned.
    function automatic logic [HALF_W-1:0] abs_h(input logic [HALF_W-1:0] v);
        abs_h = v[HALF_W-1] ? ((~v) + HALF_W'(1)) : v;
    endfunction

    assign abs_re   = abs_h(s_axis_tdata[HALF_W-1:0]);
    assign abs_im   = abs_h(s_axis_tdata[DATA_W-1:HALF_W]);
    assign mag      = {1'b0, abs_re} + {1'b0, abs_im};

    assign beat     = s_axis_tvalid && tready_q;
    assign at_last  = (idx_q == LAST_IDX);
    assign close    = beat && (s_axis_tlast || at_last);

    // First beat of a frame always loads; ties keep the lower index.
    assign take_new = (idx_q == '0) || (mag > run_max_q);
    assign cur_max  = take_new ? mag   : run_max_q;
    assign cur_bin  = take_new ? idx_q : run_bin_q;

    // State, ready and backpressure generators.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state_q  <= IDLE;
            tready_q <= 1'b0;
            cnt_q    <= 8'd0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
        end
    end

    // Next state and next ready; ready only ever comes from registers.
    always_comb begin
        state_d  = state_q;
        tready_d = 1'b0;
        cnt_d    = cnt_q;
        lfsr_d   = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = RECV;
            end
            RECV: begin
                if (!enable) state_d = IDLE;
                unique case (bp_mode)
                    2'd0: tready_d = 1'b1;
                    2'd1: tready_d = 1'b0;
                    2'd2: begin
                        tready_d = (cnt_q == 8'd0);
                        cnt_d    = (cnt_q >= bp_period) ? 8'd0
                                                        : cnt_q + 8'd1;
                    end
                    2'd3: tready_d = lfsr_q[0];
                    default: tready_d = 1'b0;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame tracking, peak latch and error bookkeeping.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            idx_q         <= '0;
            run_max_q     <= '0;
            run_bin_q     <= '0;
            frame_done_q  <= 1'b0;
            peak_bin_q    <= '0;
            peak_mag_q    <= '0;
            frame_count_q <= 16'd0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            frame_done_q <= 1'b0;
            if (close) begin
                idx_q         <= '0;
                frame_done_q  <= 1'b1;
                peak_bin_q    <= cur_bin;
                peak_mag_q    <= cur_max;
                frame_count_q <= frame_count_q + 16'd1;
                if (s_axis_tlast && !at_last) begin
                    err_early_q <= 1'b1;
                end
                if (!s_axis_tlast) begin
                    err_missing_q <= 1'b1;
                end
                if (!(s_axis_tlast && at_last) && err_count_q != 8'hFF) begin
                    err_count_q <= err_count_q + 8'd1;
                end
            end else if (beat) begin
                idx_q     <= idx_q + IDX_W'(1);
                run_max_q <= cur_max;
                run_bin_q <= cur_bin;
            end
        end
    end

    assign s_axis_tready    = tready_q;
    assign frame_done       = frame_done_q;
    assign peak_bin         = peak_bin_q;
    assign peak_mag         = peak_mag_q;
    assign frame_count      = frame_count_q;
    assign err_early_last   = err_early_q;
    assign err_missing_last = err_missing_q;
    assign err_count        = err_count_q;

endmodule
